// File: rtl/j1_boot_loader.sv
// Boot loader for the j1 core: holds the core in reset, streams a framed image
// into code RAM, then releases it. Optional checksum byte: J1_BOOT_CHECKSUM_EN.
module j1_boot_loader #(
   parameter int          ADDR_W      = 13,
   parameter int unsigned MAX_WORDS   = 8192,
   parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
   parameter int          RELEASE_DLY = 4
) (
   input  logic              clk,
   input  logic              resetq,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   input  logic              reload,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [15:0]       ram_wdata,
   output logic              cpu_resetq,
   output logic              busy,
   output logic              load_err
);

   localparam int DLY_W = (RELEASE_DLY < 1) ? 1 : $clog2(RELEASE_DLY + 1);

   typedef enum logic [3:0] {
      S_SYNC,
      S_LEN_LO,
      S_LEN_HI,
      S_DAT_LO,
      S_DAT_HI,
      S_CHK,
      S_RELEASE,
      S_RUN,
      S_ERR
   } state_t;

   state_t             r_state;
   state_t             w_next;
   state_t             w_done;
   logic [7:0]         r_len_lo;
   logic [15:0]        r_len;
   logic [7:0]         r_lo;
   logic [15:0]        r_cnt;
   logic [DLY_W-1:0]   r_dly;
   logic               r_we;
   logic [ADDR_W-1:0]  r_addr;
   logic [15:0]        r_wdata;
   logic               r_cpu_resetq;
   logic               r_err;
   logic               w_rx_ready;
   logic               w_accept;
   logic [15:0]        w_len_new;
   logic [15:0]        w_cnt_inc;
`ifdef J1_BOOT_CHECKSUM_EN
   logic [7:0]         r_chk;
`endif

   assign w_rx_ready = (r_state != S_RELEASE) && (r_state != S_RUN) && (r_state != S_ERR);
   // reload takes priority: a byte offered in the same cycle is dropped
   assign w_accept   = rx_valid && w_rx_ready && !reload;
   assign w_len_new  = {rx_data, r_len_lo};
   assign w_cnt_inc  = r_cnt + 16'd1;

   always_comb begin
`ifdef J1_BOOT_CHECKSUM_EN
      w_done = S_CHK;
`else
      w_done = S_RELEASE;
`endif
   end

   always_comb begin
      w_next = r_state;
      if (reload) begin
         w_next = S_SYNC;
      end else begin
         case (r_state)
            S_SYNC:
               if (w_accept && rx_data == SYNC_BYTE) w_next = S_LEN_LO;
            S_LEN_LO:
               if (w_accept) w_next = S_LEN_HI;
            S_LEN_HI:
               if (w_accept) begin
                  if (w_len_new == 16'd0)                  w_next = w_done;
                  else if ({16'd0, w_len_new} > MAX_WORDS) w_next = S_ERR;
                  else                                     w_next = S_DAT_LO;
               end
            S_DAT_LO:
               if (w_accept) w_next = S_DAT_HI;
            S_DAT_HI:
               if (w_accept) w_next = (w_cnt_inc == r_len) ? w_done : S_DAT_LO;
`ifdef J1_BOOT_CHECKSUM_EN
            S_CHK:
               if (w_accept) w_next = (rx_data == r_chk) ? S_RELEASE : S_ERR;
`endif
            S_RELEASE:
               if (r_dly == DLY_W'(RELEASE_DLY)) w_next = S_RUN;
            S_RUN:
               w_next = S_RUN;
            S_ERR:
               w_next = S_SYNC;
            default:
               w_next = S_SYNC;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         r_state      <= S_SYNC;
         r_len_lo     <= '0;
         r_len        <= '0;
         r_lo         <= '0;
         r_cnt        <= '0;
         r_dly        <= '0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_cpu_resetq <= 1'b0;
         r_err        <= 1'b0;
`ifdef J1_BOOT_CHECKSUM_EN
         r_chk        <= '0;
`endif
      end else begin
         r_state      <= w_next;
         r_we         <= 1'b0;
         r_cpu_resetq <= (w_next == S_RUN);
         r_dly        <= (r_state == S_RELEASE) ? r_dly + 1'b1 : '0;
         if (w_next == S_ERR) r_err <= 1'b1;
         if (w_accept) begin
            case (r_state)
               S_SYNC:
                  if (rx_data == SYNC_BYTE) begin
                     r_err <= 1'b0;
                     r_cnt <= '0;
`ifdef J1_BOOT_CHECKSUM_EN
                     r_chk <= '0;
`endif
                  end
               S_LEN_LO: begin
                  r_len_lo <= rx_data;
`ifdef J1_BOOT_CHECKSUM_EN
                  r_chk    <= rx_data;
`endif
               end
               S_LEN_HI: begin
                  r_len <= w_len_new;
`ifdef J1_BOOT_CHECKSUM_EN
                  r_chk <= r_chk ^ rx_data;
`endif
               end
               S_DAT_LO: begin
                  r_lo  <= rx_data;
`ifdef J1_BOOT_CHECKSUM_EN
                  r_chk <= r_chk ^ rx_data;
`endif
               end
               S_DAT_HI: begin
                  r_we    <= 1'b1;
                  r_wdata <= {rx_data, r_lo};
                  r_addr  <= r_cnt[ADDR_W-1:0];
                  r_cnt   <= w_cnt_inc;
`ifdef J1_BOOT_CHECKSUM_EN
                  r_chk   <= r_chk ^ rx_data;
`endif
               end
               default: ;
            endcase
         end
      end
   end

   assign rx_ready   = w_rx_ready;
   assign ram_we     = r_we;
   assign ram_addr   = r_addr;
   assign ram_wdata  = r_wdata;
   assign cpu_resetq = r_cpu_resetq;
   assign busy       = (r_state != S_RUN);
   assign load_err   = r_err;

endmodule

// File: tb/tb_j1_boot_loader.sv
// Scoreboard bench for j1_boot_loader: expected RAM writes are queued by the
// stimulus and consumed by a monitor watching ram_we.
module tb_j1_boot_loader;

   localparam int ADDR_W      = 13;
   localparam int RELEASE_DLY = 4;

   typedef logic [7:0] byte_q_t[$];

   logic              clk = 1'b0;
   logic              resetq = 1'b0;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_ready;
   logic              reload = 1'b0;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [15:0]       ram_wdata;
   logic              cpu_resetq;
   logic              busy;
   logic              load_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_we_cyc = 0;
   int run_cyc = 0;
   logic [28:0] exp_q[$];

   j1_boot_loader #(
      .ADDR_W(ADDR_W), .MAX_WORDS(8192), .SYNC_BYTE(8'hA5), .RELEASE_DLY(RELEASE_DLY)
   ) dut (
      .clk(clk), .resetq(resetq), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ready(rx_ready), .reload(reload), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .cpu_resetq(cpu_resetq), .busy(busy), .load_err(load_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the oldest queued expectation
   always @(negedge clk) begin
      if (ram_we === 1'b1) begin
         last_we_cyc = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ram_we: got addr %0h data %0h expected no write", ram_addr, ram_wdata);
         end else begin
            check("ram_write", {3'b0, ram_addr, ram_wdata}, {3'b0, exp_q.pop_front()});
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) begin
         check("rx_ready_timeout", {31'b0, rx_ready}, 32'd1);
         rx_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1 rx_valid = 1'b0;
      end
   endtask

   task automatic send_bytes(input byte_q_t q);
      foreach (q[i]) send_byte(q[i]);
   endtask

   task automatic pulse_reload();
      @(negedge clk);
      reload = 1'b1;
      @(posedge clk);
      #1 reload = 1'b0;
   endtask

   task automatic wait_run(input string name);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cpu_resetq) break;
      end
      run_cyc = cyc;
      check(name, {31'b0, cpu_resetq}, 32'd1);
      check({name, "_busy"}, {31'b0, busy}, 32'd0);
   endtask

   task automatic push_frame1();
      exp_q.push_back({13'd0, 16'h1234});
      exp_q.push_back({13'd1, 16'h5678});
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_cpu_resetq"}, {31'b0, cpu_resetq}, 32'd0);
      check({name, "_ram_we"},     {31'b0, ram_we},     32'd0);
      check({name, "_ram_addr"},   {19'b0, ram_addr},   32'd0);
      check({name, "_ram_wdata"},  {16'b0, ram_wdata},  32'd0);
      check({name, "_busy"},       {31'b0, busy},       32'd1);
      check({name, "_load_err"},   {31'b0, load_err},   32'd0);
      check({name, "_rx_ready"},   {31'b0, rx_ready},   32'd1);
   endtask

   initial begin
      byte_q_t f1;
      byte_q_t f;
      f1 = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
`ifdef J1_BOOT_CHECKSUM_EN
      f1.push_back(8'h0A);
`endif

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      resetq = 1'b1;
      @(negedge clk);
      check_reset_outputs("post_reset");

      // Frame 1: two words, then release timing
      push_frame1();
      send_bytes(f1);
      wait_run("frame1_run");
`ifndef J1_BOOT_CHECKSUM_EN
      check("frame1_release_dly", run_cyc - last_we_cyc, RELEASE_DLY + 1);
`endif
      check("run_rx_ready", {31'b0, rx_ready}, 32'd0);

      // Reload together with an offered byte while running
      @(negedge clk);
      reload = 1'b1;
      rx_valid = 1'b1;
      rx_data = 8'hA5;
      @(posedge clk);
      #1 reload = 1'b0;
      rx_valid = 1'b0;
      @(negedge clk);
      check("reload_cpu_resetq", {31'b0, cpu_resetq}, 32'd0);
      check("reload_busy", {31'b0, busy}, 32'd1);
      check("reload_rx_ready", {31'b0, rx_ready}, 32'd1);
      push_frame1();
      send_bytes(f1);
      wait_run("reload_frame1_run");

      // Garbage before sync, empty image
      pulse_reload();
      f = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
`ifdef J1_BOOT_CHECKSUM_EN
      f.push_back(8'h00);
`endif
      send_bytes(f);
      wait_run("empty_run");
      check("empty_load_err", {31'b0, load_err}, 32'd0);

      // Oversized length: 0x2101, then boundary 0x2001
      pulse_reload();
      f = '{8'hA5, 8'h01, 8'h21};
      send_bytes(f);
      @(negedge clk);
      check("len_err_flag", {31'b0, load_err}, 32'd1);
      check("len_err_rx_ready", {31'b0, rx_ready}, 32'd0);
      check("len_err_cpu_resetq", {31'b0, cpu_resetq}, 32'd0);
      @(negedge clk);
      check("len_err_back_sync", {31'b0, rx_ready}, 32'd1);
      check("len_err_sticky", {31'b0, load_err}, 32'd1);
      send_byte(8'hA5);
      @(negedge clk);
      check("len_err_cleared", {31'b0, load_err}, 32'd0);
      f = '{8'h01, 8'h20};
      send_bytes(f);
      @(negedge clk);
      check("len_2001_err", {31'b0, load_err}, 32'd1);
      f = '{8'hA5, 8'h00, 8'h00};
`ifdef J1_BOOT_CHECKSUM_EN
      f.push_back(8'h00);
`endif
      send_bytes(f);
      wait_run("recover_run");
      check("recover_load_err", {31'b0, load_err}, 32'd0);

`ifdef J1_BOOT_CHECKSUM_EN
      // Bad checksum: RAM written, core kept in reset
      pulse_reload();
      push_frame1();
      f = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h00};
      send_bytes(f);
      @(negedge clk);
      check("chk_err_flag", {31'b0, load_err}, 32'd1);
      repeat (10) @(negedge clk);
      check("chk_err_cpu_resetq", {31'b0, cpu_resetq}, 32'd0);
      check("chk_err_busy", {31'b0, busy}, 32'd1);
`endif

      // Async reset mid-frame, then a clean reload from address 0
      pulse_reload();
      f = '{8'hA5, 8'h02, 8'h00, 8'h34};
      send_bytes(f);
      resetq = 1'b0;
      #1;
      check_reset_outputs("midframe_reset");
      @(negedge clk);
      resetq = 1'b1;
      push_frame1();
      send_bytes(f1);
      wait_run("after_reset_run");
`ifndef J1_BOOT_CHECKSUM_EN
      check("after_reset_release_dly", run_cyc - last_we_cyc, RELEASE_DLY + 1);
`endif

      repeat (3) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
